// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode values and the
// multiply/divide sequencer state encoding. The control unit imports this too.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REMU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // True for opcodes whose result comes from result_DR rather than the
  // combinational ALU (the iterative multiply/divide group).
  function automatic logic alu_is_multi(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative multiply/divide sequencer. Owns the start/busy/done handshake and
// tells the top when (and with what) to load result_DR. Multiply is shift-add,
// LSB first; divide is restoring, MSB first; both take 32 iterations.
module seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] fast_res_i,
  output logic             wr_en_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             busy_o,
  output logic             done_o
);
  import alu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;
  // opa: multiplicand shifting left (MUL) or dividend/quotient shifter (DIV)
  logic [WIDTH-1:0] opa_q, opa_d;
  // opb: multiplier shifting right (MUL) or divisor (DIV)
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_rem_q, is_rem_d;

  logic             accept_s;
  logic             is_div_s;
  logic             div0_s;
  logic             last_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   div_sh_s;
  logic [WIDTH:0]   div_diff_s;
  logic             div_ok_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;

  // Request decode: start only counts in IDLE; op/operands sampled here only.
  always_comb begin
    accept_s = (state_q == ST_IDLE) && start_i;
    is_div_s = (op_i == ALU_DIVU) || (op_i == ALU_REMU);
    div0_s   = (b_i == ZERO_W);
    last_s   = (cnt_q == CNT_LAST);
  end

  // One shift-add step and one restoring-divide step from the latched operands.
  always_comb begin
    mul_acc_s  = acc_q + (opb_q[0] ? opa_q : ZERO_W);
    div_sh_s   = {acc_q, opa_q[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, opb_q};
    div_ok_s   = ~div_diff_s[WIDTH];
    div_rem_s  = div_ok_s ? div_diff_s[WIDTH-1:0] : div_sh_s[WIDTH-1:0];
    div_quo_s  = {opa_q[WIDTH-2:0], div_ok_s};
  end

  // FSM next state: single-cycle ops and divide-by-zero go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_i == ALU_MUL) begin
            state_d = ST_MUL;
          end else if (is_div_s && !div0_s) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: latch operands on accept, iterate in MUL/DIV.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_rem_d = is_rem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && ((op_i == ALU_MUL) || (is_div_s && !div0_s))) begin
          cnt_d    = CNT_ZERO;
          acc_d    = ZERO_W;
          opa_d    = a_i;
          opb_d    = b_i;
          is_rem_d = (op_i == ALU_REMU);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + CNT_ONE;
        acc_d = mul_acc_s;
        opa_d = {opa_q[WIDTH-2:0], 1'b0};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
      end
      ST_DIV: begin
        cnt_d = cnt_q + CNT_ONE;
        acc_d = div_rem_s;
        opa_d = div_quo_s;
      end
      ST_DONE: cnt_d = cnt_q;
      default: cnt_d = CNT_ZERO;
    endcase
  end

  // FSM outputs: busy/done are pure state decodes; the write strobe fires on
  // the edge that enters DONE, so result_DR is valid while done is high.
  always_comb begin
    busy_o    = (state_q == ST_MUL) || (state_q == ST_DIV);
    done_o    = (state_q == ST_DONE);
    wr_en_o   = 1'b0;
    wr_data_o = ZERO_W;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (op_i != ALU_MUL) && !(is_div_s && !div0_s)) begin
          wr_en_o = 1'b1;
          if (is_div_s) begin
            wr_data_o = (op_i == ALU_DIVU) ? ONES_W : a_i;
          end else begin
            wr_data_o = fast_res_i;
          end
        end else begin
          wr_en_o = 1'b0;
        end
      end
      ST_MUL: begin
        if (last_s) begin
          wr_en_o   = 1'b1;
          wr_data_o = mul_acc_s;
        end else begin
          wr_en_o = 1'b0;
        end
      end
      ST_DIV: begin
        if (last_s) begin
          wr_en_o   = 1'b1;
          wr_data_o = is_rem_q ? div_rem_s : div_quo_s;
        end else begin
          wr_en_o = 1'b0;
        end
      end
      ST_DONE: wr_en_o = 1'b0;
      default: wr_en_o = 1'b0;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      acc_q    <= ZERO_W;
      opa_q    <= ZERO_W;
      opb_q    <= ZERO_W;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_rem_q <= is_rem_d;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: combinational ALU, result mux to the memory stage, and the
// result_DR register used as the memory address. Multiply/divide is delegated
// to seq_muldiv, which also owns the busy/done handshake.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_DR,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  import alu_pkg::*;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic [WIDTH-1:0] fast_res_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] result_dr_q, result_dr_d;

  // Single-cycle ALU functions; multi-cycle and unused opcodes give zero here.
  always_comb begin
    fast_res_s = ZERO_W;
    case (alu_op)
      ALU_ADD:  fast_res_s = a + b;
      ALU_SUB:  fast_res_s = a - b;
      ALU_SLL:  fast_res_s = b << a[CNT_W-1:0];
      ALU_OR:   fast_res_s = a | b;
      ALU_AND:  fast_res_s = a & b;
      ALU_SLTU: fast_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLT:  fast_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR:  fast_res_s = a ^ b;
      default:  fast_res_s = ZERO_W;
    endcase
  end

  // Result to the write-back mux: multi-cycle opcodes expose the register.
  always_comb begin
    if (alu_is_multi(alu_op)) begin
      result = result_dr_q;
    end else begin
      result = fast_res_s;
    end
    zero = (result == ZERO_W);
  end

  // result_DR only changes when the sequencer reports a finished operation.
  always_comb begin
    if (wr_en_s) begin
      result_dr_d = wr_data_s;
    end else begin
      result_dr_d = result_dr_q;
    end
  end

  // result_DR register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_dr_q <= ZERO_W;
    end else begin
      result_dr_q <= result_dr_d;
    end
  end

  assign result_DR = result_dr_q;

  seq_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq_muldiv (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .op_i       (alu_op),
    .a_i        (a),
    .b_i        (b),
    .fast_res_i (fast_res_s),
    .wr_en_o    (wr_en_s),
    .wr_data_o  (wr_data_s),
    .busy_o     (busy),
    .done_o     (done)
  );

endmodule
